data_ram_arbiter: RTL and testbench
===================================

Name: data_ram_arbiter

Overview:
- Shares the single-port synchronous data RAM (`memory_inst.ram1`) between two requesters: the unpipelined processor load/store port (CPU) and an external port (EXT: debug/firmware loader).
- One RAM access per cycle.
- Requesters use a req/gnt handshake; read data returns one cycle after the grant.
- Sits in `soc` between `processor_unpipelined`, the debug port and `memory_inst`.

Parameters:
- ADDR_WIDTH, 8, RAM word-address width.
- DATA_WIDTH, 32, data word width.
- EXT_MAX_WAIT, 4, maximum consecutive cycles EXT may wait while CPU wins (fixed-priority mode); legal range 1..15.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset (reset==0 resets on the next rising clk edge).
- cpu_req  in  1  CPU access request; held with its fields until granted.
- cpu_we  in  1  1=write, 0=read.
- cpu_addr  in  ADDR_WIDTH  CPU word address.
- cpu_wdata  in  DATA_WIDTH  CPU write data.
- cpu_gnt  out  1  CPU access issued to RAM this cycle.
- cpu_stall  out  1  cpu_req & ~cpu_gnt; freezes processor PC update.
- cpu_rvalid  out  1  CPU read data valid.
- cpu_rdata  out  DATA_WIDTH  CPU read data.
- ext_req, ext_we, ext_addr, ext_wdata  in  1/1/ADDR_WIDTH/DATA_WIDTH  same meaning for EXT.
- ext_gnt  out  1  EXT access issued this cycle.
- ext_rvalid  out  1  EXT read data valid.
- ext_rdata  out  DATA_WIDTH  EXT read data.
- ram_en  out  1  RAM enable.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_WIDTH  RAM address.
- ram_wdata  out  DATA_WIDTH  RAM write data.
- ram_rdata  in  DATA_WIDTH  RAM read data, valid one cycle after a read enable.

Behaviour:
- **Registered state:**
  - owner_q (IDLE/CPU/EXT): owner of the access issued last cycle; doubles as the FSM state.
  - rd_pend_q: last access was a read.
  - wait_cnt (4 bits).
  - last_q: last granted requester, for round-robin.
- **Reset values:**
  - owner_q=IDLE, rd_pend_q=0, wait_cnt=0, last_q=EXT (CPU wins first tie).
  - While reset==0: all gnt, rvalid, ram_en and ram_we are 0; rdata outputs are 0.
- **Grant selection** (combinational from current requests plus registered state; at most one gnt per cycle):
  - Neither requesting: no grant; ram_en=0.
  - Only one requesting: that one is granted.
  - Both requesting, fixed priority: CPU is granted unless wait_cnt==EXT_MAX_WAIT, in which case EXT is granted.
- **Granted access:**
  - ram_en=1; ram_we, ram_addr and ram_wdata are muxed from the winner.
  - The handshake completes on the clock edge where req and gnt are both high.
  - The requester may present a new request in the following cycle.
- **wait_cnt:**
  - Increments when ext_req & ~ext_gnt; saturates at EXT_MAX_WAIT.
  - Clears on ext_gnt or when ext_req==0.
- **FSM transitions:** each edge, owner_q takes the granted requester (CPU or EXT), or IDLE if none. rd_pend_q = granted & ~we.
- **Read return:**
  - The cycle after a granted read, the owner's rvalid=1 and its rdata=ram_rdata.
  - The other requester's rvalid=0 and its rdata holds its previous value.
  - Writes produce no rvalid.
- **Back-to-back:**
  - A read can be granted in the same cycle that the previous read's data returns.
  - Throughput is one access per cycle.
- **Reset mid-operation:**
  - A granted read whose return cycle coincides with reset==0 produces no rvalid.
  - A pending request is dropped; the requester must re-request after reset.
- **Address range:** full ADDR_WIDTH range; no checking or wrap logic (RAM decodes).

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: when both request, the requester other than last_q is granted (strict alternation). wait_cnt is not instantiated, and EXT_MAX_WAIT is ignored.
- Undefined: CPU fixed priority with the EXT_MAX_WAIT starvation override described above.

Test Plan:
- Reset: hold reset=0 for 2 cycles with cpu_req=ext_req=1 -> cpu_gnt=ext_gnt=0, ram_en=0, both rvalid=0, both rdata=0.
- CPU alone: write addr 3 data 28, next cycle read addr 3 -> cpu_gnt in each cycle, ram_we=1 then 0; cpu_rvalid=1 with cpu_rdata=28 exactly one cycle after the read grant; ext_rvalid=0 throughout.
- EXT alone: write addr 4 data 0xDEADBEEF, then CPU read addr 4 -> cpu_rdata=0xDEADBEEF; no gnt overlap.
- Fixed priority, EXT_MAX_WAIT=4, both requesting continuously for 10 cycles -> grant sequence CPU,CPU,CPU,CPU,EXT,CPU,CPU,CPU,CPU,EXT; cpu_stall=1 exactly in the EXT cycles.
- ARB_ROUND_ROBIN_EN defined, both requesting continuously for 6 cycles from reset -> CPU,EXT,CPU,EXT,CPU,EXT.
- Reset mid-read: CPU read addr 3 granted, reset=0 at the next edge -> cpu_rvalid stays 0; after reset release with no requests, ram_en=0.

Source files
------------

// File: rtl/data_ram_arbiter.sv
// data_ram_arbiter: shares one single-port synchronous data RAM between the CPU
// load/store port and an external (debug/loader) port. One access per cycle,
// req/gnt handshake, read data returned one cycle after the grant.
// Build option: ARB_ROUND_ROBIN_EN selects strict alternation on ties instead of
// CPU fixed priority with the EXT_MAX_WAIT starvation override.
module data_ram_arbiter #(
    parameter int unsigned ADDR_WIDTH   = 8,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned EXT_MAX_WAIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_gnt,
    output logic                  cpu_stall,
    output logic                  cpu_rvalid,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    input  logic                  ext_req,
    input  logic                  ext_we,
    input  logic [ADDR_WIDTH-1:0] ext_addr,
    input  logic [DATA_WIDTH-1:0] ext_wdata,
    output logic                  ext_gnt,
    output logic                  ext_rvalid,
    output logic [DATA_WIDTH-1:0] ext_rdata,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    typedef enum logic [1:0] {OwnIdle, OwnCpu, OwnExt} owner_t;

    owner_t                owner_q, owner_d;
    logic                  rd_pend_q, rd_pend_d;
    logic [DATA_WIDTH-1:0] cpu_rdata_q, ext_rdata_q;

`ifdef ARB_ROUND_ROBIN_EN
    owner_t                last_q, last_d;
`else
    localparam logic [3:0] MaxWait = 4'(EXT_MAX_WAIT);
    logic [3:0]            wait_cnt, wait_d;
`endif

    // Grant selection; nothing is granted while reset is asserted.
    always_comb begin
        cpu_gnt = 1'b0;
        ext_gnt = 1'b0;
        if (reset) begin
            if (cpu_req && ext_req) begin
`ifdef ARB_ROUND_ROBIN_EN
                if (last_q == OwnCpu) begin
                    ext_gnt = 1'b1;
                end else begin
                    cpu_gnt = 1'b1;
                end
`else
                if (wait_cnt == MaxWait) begin
                    ext_gnt = 1'b1;
                end else begin
                    cpu_gnt = 1'b1;
                end
`endif
            end else if (cpu_req) begin
                cpu_gnt = 1'b1;
            end else if (ext_req) begin
                ext_gnt = 1'b1;
            end
        end
    end

    // RAM port mux, stall, and next-state for owner/read-pending/fairness state.
    always_comb begin
        ram_en    = cpu_gnt | ext_gnt;
        ram_we    = ext_gnt ? ext_we : (cpu_gnt & cpu_we);
        ram_addr  = ext_gnt ? ext_addr : cpu_addr;
        ram_wdata = ext_gnt ? ext_wdata : cpu_wdata;
        cpu_stall = cpu_req & ~cpu_gnt;

        owner_d   = OwnIdle;
        if (cpu_gnt) begin
            owner_d = OwnCpu;
        end else if (ext_gnt) begin
            owner_d = OwnExt;
        end
        rd_pend_d = ram_en & ~ram_we;

`ifdef ARB_ROUND_ROBIN_EN
        last_d = last_q;
        if (cpu_gnt) begin
            last_d = OwnCpu;
        end else if (ext_gnt) begin
            last_d = OwnExt;
        end
`else
        wait_d = wait_cnt;
        if (!ext_req || ext_gnt) begin
            wait_d = '0;
        end else if (wait_cnt < MaxWait) begin
            wait_d = wait_cnt + 4'd1;
        end
`endif
    end

    // Read return: the previous cycle's owner sees the RAM output; the other side holds.
    always_comb begin
        cpu_rvalid = reset & rd_pend_q & (owner_q == OwnCpu);
        ext_rvalid = reset & rd_pend_q & (owner_q == OwnExt);
        cpu_rdata  = '0;
        ext_rdata  = '0;
        if (reset) begin
            cpu_rdata = cpu_rvalid ? ram_rdata : cpu_rdata_q;
            ext_rdata = ext_rvalid ? ram_rdata : ext_rdata_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            owner_q     <= OwnIdle;
            rd_pend_q   <= 1'b0;
            cpu_rdata_q <= '0;
            ext_rdata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_q      <= OwnExt;
`else
            wait_cnt    <= '0;
`endif
        end else begin
            owner_q   <= owner_d;
            rd_pend_q <= rd_pend_d;
            if (cpu_rvalid) begin
                cpu_rdata_q <= ram_rdata;
            end
            if (ext_rvalid) begin
                ext_rdata_q <= ram_rdata;
            end
`ifdef ARB_ROUND_ROBIN_EN
            last_q    <= last_d;
`else
            wait_cnt  <= wait_d;
`endif
        end
    end

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Testbench for data_ram_arbiter: directed scenarios with literal expectations plus
// a randomized phase, all checked every cycle against a transaction-level model.
module tb_data_ram_arbiter;

    localparam int AW      = 8;
    localparam int DW      = 32;
    localparam int MAXWAIT = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_req, cpu_we, ext_req, ext_we;
    logic [AW-1:0] cpu_addr, ext_addr;
    logic [DW-1:0] cpu_wdata, ext_wdata;
    logic          cpu_gnt, cpu_stall, cpu_rvalid, ext_gnt, ext_rvalid;
    logic [DW-1:0] cpu_rdata, ext_rdata;
    logic          ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata = '0;

    logic [DW-1:0] tb_ram [256] = '{default: '0};

    int total = 0;
    int bad   = 0;

    // Transaction-level model state
    logic [DW-1:0] model_mem [256] = '{default: '0};
    int            m_win;        // 0 none, 1 cpu, 2 ext
    int            m_wait;       // consecutive cycles EXT requested and lost
    int            m_last;       // 0 cpu, 1 ext
    bit            m_cpu_pend, m_ext_pend;
    logic [DW-1:0] m_cpu_pdata, m_ext_pdata, m_cpu_hold, m_ext_hold;

    // Observed values from the latest compare point
    logic          obs_cpu_gnt, obs_ext_gnt, obs_cpu_stall, obs_ram_en, obs_ram_we;
    logic          obs_cpu_rvalid, obs_ext_rvalid;
    logic [DW-1:0] obs_cpu_rdata, obs_ext_rdata;

    always #5 clk = ~clk;

    data_ram_arbiter #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .EXT_MAX_WAIT(MAXWAIT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_gnt   (cpu_gnt),
        .cpu_stall (cpu_stall),
        .cpu_rvalid(cpu_rvalid),
        .cpu_rdata (cpu_rdata),
        .ext_req   (ext_req),
        .ext_we    (ext_we),
        .ext_addr  (ext_addr),
        .ext_wdata (ext_wdata),
        .ext_gnt   (ext_gnt),
        .ext_rvalid(ext_rvalid),
        .ext_rdata (ext_rdata),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    // Single-port synchronous RAM
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) tb_ram[ram_addr] <= ram_wdata;
            else        ram_rdata <= tb_ram[ram_addr];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic int winner();
        if (!reset) return 0;
        if (cpu_req && ext_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            return (m_last == 1) ? 1 : 2;
`else
            return (m_wait >= MAXWAIT) ? 2 : 1;
`endif
        end
        if (cpu_req) return 1;
        if (ext_req) return 2;
        return 0;
    endfunction

    // Compare all outputs against the model for the current cycle.
    task automatic compare_cycle();
        logic          e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata;
        m_win = winner();
        chk("cpu_gnt", 64'(cpu_gnt), 64'(m_win == 1));
        chk("ext_gnt", 64'(ext_gnt), 64'(m_win == 2));
        chk("cpu_stall", 64'(cpu_stall), 64'(cpu_req && m_win != 1));
        chk("ram_en", 64'(ram_en), 64'(m_win != 0));
        if (m_win != 0) begin
            e_we    = (m_win == 1) ? cpu_we : ext_we;
            e_addr  = (m_win == 1) ? cpu_addr : ext_addr;
            e_wdata = (m_win == 1) ? cpu_wdata : ext_wdata;
            chk("ram_we", 64'(ram_we), 64'(e_we));
            chk("ram_addr", 64'(ram_addr), 64'(e_addr));
            if (e_we) chk("ram_wdata", 64'(ram_wdata), 64'(e_wdata));
        end else begin
            chk("ram_we_idle", 64'(ram_we), 64'(0));
        end
        chk("cpu_rvalid", 64'(cpu_rvalid), 64'(reset && m_cpu_pend));
        chk("ext_rvalid", 64'(ext_rvalid), 64'(reset && m_ext_pend));
        chk("cpu_rdata", 64'(cpu_rdata),
            64'(!reset ? '0 : (m_cpu_pend ? m_cpu_pdata : m_cpu_hold)));
        chk("ext_rdata", 64'(ext_rdata),
            64'(!reset ? '0 : (m_ext_pend ? m_ext_pdata : m_ext_hold)));
        obs_cpu_gnt    = cpu_gnt;
        obs_ext_gnt    = ext_gnt;
        obs_cpu_stall  = cpu_stall;
        obs_ram_en     = ram_en;
        obs_ram_we     = ram_we;
        obs_cpu_rvalid = cpu_rvalid;
        obs_ext_rvalid = ext_rvalid;
        obs_cpu_rdata  = cpu_rdata;
        obs_ext_rdata  = ext_rdata;
    endtask

    // Advance the model across the clock edge using the decided winner.
    task automatic update_model();
        if (!reset) begin
            m_wait = 0; m_last = 1;
            m_cpu_pend = 0; m_ext_pend = 0;
            m_cpu_hold = '0; m_ext_hold = '0;
        end else begin
            if (m_cpu_pend) m_cpu_hold = m_cpu_pdata;
            if (m_ext_pend) m_ext_hold = m_ext_pdata;
            m_cpu_pend = 0;
            m_ext_pend = 0;
            if (m_win == 1) begin
                if (cpu_we) model_mem[cpu_addr] = cpu_wdata;
                else begin m_cpu_pend = 1; m_cpu_pdata = model_mem[cpu_addr]; end
                m_last = 0;
            end else if (m_win == 2) begin
                if (ext_we) model_mem[ext_addr] = ext_wdata;
                else begin m_ext_pend = 1; m_ext_pdata = model_mem[ext_addr]; end
                m_last = 1;
            end
            if (ext_req && m_win != 2) begin
                if (m_wait < 1000) m_wait++;
            end else begin
                m_wait = 0;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        compare_cycle();
        @(posedge clk);
        update_model();
        #1;
    endtask

    initial begin
        logic [9:0] prio_pat;
        logic [5:0] rr_pat;
        bit         cpu_new, ext_new;

        m_wait = 0; m_last = 1; m_win = 0;
        m_cpu_pend = 0; m_ext_pend = 0;
        m_cpu_hold = '0; m_ext_hold = '0; m_cpu_pdata = '0; m_ext_pdata = '0;
        reset = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = '0; ext_wdata = '0;

        // Reset held with both requesting
        for (int i = 0; i < 2; i++) begin
            step();
            chk("rst_cpu_gnt", 64'(obs_cpu_gnt), 64'(0));
            chk("rst_ext_gnt", 64'(obs_ext_gnt), 64'(0));
            chk("rst_ram_en", 64'(obs_ram_en), 64'(0));
            chk("rst_rvalid", 64'({obs_cpu_rvalid, obs_ext_rvalid}), 64'(0));
            chk("rst_rdata", 64'({obs_cpu_rdata, obs_ext_rdata}), 64'(0));
        end

        // CPU alone: write 28 to addr 3, then read it back
        reset = 1'b1; ext_req = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'd3; cpu_wdata = 32'd28;
        step();
        chk("cpu_wr_gnt", 64'({obs_cpu_gnt, obs_ram_we}), 64'(2'b11));
        cpu_we = 1'b0;
        step();
        chk("cpu_rd_gnt", 64'({obs_cpu_gnt, obs_ram_we}), 64'(2'b10));
        chk("cpu_rd_no_rvalid", 64'(obs_cpu_rvalid), 64'(0));
        cpu_req = 1'b0;
        step();
        chk("cpu_rd_rvalid", 64'(obs_cpu_rvalid), 64'(1));
        chk("cpu_rd_data", 64'(obs_cpu_rdata), 64'(28));
        chk("cpu_rd_ext_rvalid", 64'(obs_ext_rvalid), 64'(0));

        // EXT writes, CPU reads back
        ext_req = 1'b1; ext_we = 1'b1; ext_addr = 8'd4; ext_wdata = 32'hDEADBEEF;
        step();
        chk("ext_wr_gnt", 64'({obs_ext_gnt, obs_cpu_gnt}), 64'(2'b10));
        ext_req = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'd4;
        step();
        chk("ext_then_cpu_gnt", 64'({obs_ext_gnt, obs_cpu_gnt}), 64'(2'b01));
        cpu_req = 1'b0;
        step();
        chk("ext_then_cpu_data", 64'(obs_cpu_rdata), 64'(32'hDEADBEEF));

        // Contention from reset
        reset = 1'b0;
        step();
        reset = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'd3;
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 8'd4;
`ifdef ARB_ROUND_ROBIN_EN
        rr_pat = 6'b101010;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("rr_ext_gnt", 64'(obs_ext_gnt), 64'(rr_pat[i]));
            chk("rr_cpu_gnt", 64'(obs_cpu_gnt), 64'(!rr_pat[i]));
        end
`else
        prio_pat = 10'b10_0001_0000;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("prio_ext_gnt", 64'(obs_ext_gnt), 64'(prio_pat[i]));
            chk("prio_cpu_gnt", 64'(obs_cpu_gnt), 64'(!prio_pat[i]));
            chk("prio_stall", 64'(obs_cpu_stall), 64'(prio_pat[i]));
        end
`endif

        // Reset arriving in a read's return cycle
        ext_req = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'd3;
        step();
        chk("midrst_gnt", 64'(obs_cpu_gnt), 64'(1));
        reset = 1'b0; cpu_req = 1'b0;
        step();
        chk("midrst_rvalid", 64'(obs_cpu_rvalid), 64'(0));
        reset = 1'b1;
        step();
        chk("midrst_idle_en", 64'(obs_ram_en), 64'(0));
        chk("midrst_idle_rvalid", 64'(obs_cpu_rvalid), 64'(0));

        // Randomized traffic; requesters hold until granted
        for (int n = 0; n < 3000; n++) begin
            cpu_new = !cpu_req || m_win == 1 || !reset;
            ext_new = !ext_req || m_win == 2 || !reset;
            reset = ($urandom_range(0, 59) != 0);
            if (cpu_new) begin
                cpu_req   = ($urandom_range(0, 9) < 7);
                cpu_we    = $urandom_range(0, 1) == 1;
                cpu_addr  = AW'($urandom_range(0, 15));
                cpu_wdata = $urandom;
            end
            if (ext_new) begin
                ext_req   = ($urandom_range(0, 9) < 6);
                ext_we    = $urandom_range(0, 1) == 1;
                ext_addr  = AW'($urandom_range(0, 15));
                ext_wdata = $urandom;
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
